// File: rtl/microseq_pkg.sv
// Shared types for the microprogram sequencer: instruction codes and D-source enables.
package microseq_pkg;

    localparam int unsigned SQI_W  = 4;
    localparam int unsigned DSRC_W = 3;

    typedef enum logic [SQI_W-1:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } sqi_e;

    // Packed as {pl_n, map_n, vect_n}; exactly one bit low.
    typedef enum logic [DSRC_W-1:0] {
        DSRC_PL   = 3'b011,
        DSRC_MAP  = 3'b101,
        DSRC_VECT = 3'b110
    } dsrc_e;

endpackage

// File: rtl/microseq_stack.sv
// Return-address stack: storage, stack pointer, full/empty flags.
// Sticky overflow/underflow flag is built only with MICROSEQ_STACK_ERR_EN.
module microseq_stack #(
    parameter int unsigned AW     = 12,
    parameter int unsigned SDEPTH = 5
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic [AW-1:0] din_i,
    output logic [AW-1:0] tos_o,
    output logic          full_n_o,
    output logic          empty_o,
    output logic          err_o
);
    localparam int unsigned SPW  = $clog2(SDEPTH + 1);
    localparam int unsigned IDXW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [AW-1:0]  mem_q [SDEPTH];
    logic [AW-1:0]  last_q;
    logic [SPW-1:0] sp_q, sp_d;
    logic [IDXW-1:0] wr_idx, rd_idx;
    logic           full, emp;

    assign full     = (sp_q == SPW'(SDEPTH));
    assign emp      = (sp_q == '0);
    assign full_n_o = ~full;
    assign empty_o  = emp;

    // A push into a full stack overwrites the current top entry.
    assign wr_idx = full ? IDXW'(SDEPTH - 1) : IDXW'(sp_q);
    assign rd_idx = IDXW'(sp_q - SPW'(1));
    assign tos_o  = emp ? last_q : mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = '0;
        end else if (push_i && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_i && !emp) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sp_q   <= '0;
            last_q <= '0;
            for (int k = 0; k < int'(SDEPTH); k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            if (push_i) begin
                mem_q[wr_idx] <= din_i;
                last_q        <= din_i;
            end
        end
    end

`ifdef MICROSEQ_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else if ((push_i && full) || (pop_i && emp)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/microseq.sv
// Parametrised Am2910-style microprogram sequencer with condition mux, hold and interrupt entry.
// Define MICROSEQ_STACK_ERR_EN to build the sticky stack error flag (stk_err).
module microseq
    import microseq_pkg::*;
#(
    parameter int unsigned AW     = 12,
    parameter int unsigned SDEPTH = 5,
    parameter int unsigned NCOND  = 32
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [SQI_W-1:0]         i,
    input  logic [AW-1:0]            d,
    input  logic [NCOND-1:0]         cond_vec,
    input  logic [$clog2(NCOND)-1:0] cond_sel,
    input  logic                     cond_inv,
    input  logic                     ccen_n,
    input  logic                     rld_n,
    input  logic                     ci,
    input  logic                     hold,
    input  logic                     irq_req,
    input  logic                     irq_en,
    input  logic [AW-1:0]            vec,
    output logic [AW-1:0]            y,
    output logic                     pl_n,
    output logic                     map_n,
    output logic                     vect_n,
    output logic                     full_n,
    output logic                     empty,
    output logic                     irq_ack,
    output logic                     stk_err
);
    logic [AW-1:0] upc_q, upc_d, r_q, r_d, tos, y_dec, stk_din;
    logic          pass, r_zero, irq_take, ack_q;
    logic          push_dec, pop_dec, clr_dec;
    logic          st_push, st_pop, st_clr;
    logic [DSRC_W-1:0] dsrc_out;
    dsrc_e         dsrc;
    sqi_e          op;

    assign op     = sqi_e'(i);
    assign pass   = ccen_n | (cond_vec[cond_sel] ^ cond_inv);
    assign r_zero = (r_q == '0);

    // Instruction decode: address select, stack requests and counter update.
    always_comb begin
        y_dec    = upc_q;
        dsrc     = DSRC_PL;
        push_dec = 1'b0;
        pop_dec  = 1'b0;
        clr_dec  = 1'b0;
        r_d      = r_q;
        case (op)
            JZ:   begin y_dec = '0; clr_dec = 1'b1; end
            CJS:  if (pass) begin push_dec = 1'b1; y_dec = d; end
            JMAP: begin y_dec = d; dsrc = DSRC_MAP; end
            CJP:  if (pass) y_dec = d;
            PUSH: begin push_dec = 1'b1; if (pass) r_d = d; end
            JSRP: begin push_dec = 1'b1; y_dec = pass ? d : r_q; end
            CJV:  begin dsrc = DSRC_VECT; if (pass) y_dec = d; end
            JRP:  y_dec = pass ? d : r_q;
            RFCT: if (!r_zero) begin y_dec = tos; r_d = r_q - AW'(1); end
                  else pop_dec = 1'b1;
            RPCT: if (!r_zero) begin y_dec = d; r_d = r_q - AW'(1); end
            CRTN: if (pass) begin y_dec = tos; pop_dec = 1'b1; end
            CJPP: if (pass) begin y_dec = d; pop_dec = 1'b1; end
            LDCT: r_d = d;
            LOOP: if (pass) pop_dec = 1'b1; else y_dec = tos;
            CONT: ;
            TWB:  if (pass) pop_dec = 1'b1;
                  else if (!r_zero) begin y_dec = tos; r_d = r_q - AW'(1); end
                  else begin pop_dec = 1'b1; y_dec = d; end
            default: ;
        endcase
        if (!rld_n) r_d = d;
    end

    // The ack cycle masks irq_req so a held level cannot re-enter back to back.
    assign irq_take = irq_req & irq_en & ~hold & ~ack_q;

    always_comb begin
        y        = y_dec;
        dsrc_out = dsrc;
        if (!nreset) begin
            y        = '0;
            dsrc_out = DSRC_PL;
        end else if (irq_take) begin
            y = vec;
        end
    end

    assign {pl_n, map_n, vect_n} = dsrc_out;
    assign irq_ack = ack_q & ~hold;

    // Interrupt entry replaces the instruction's own stack effect with one push.
    assign st_push = ~hold & (irq_take | push_dec);
    assign st_pop  = ~hold & ~irq_take & pop_dec;
    assign st_clr  = ~hold & ~irq_take & clr_dec;
    assign stk_din = irq_take ? y_dec : upc_q;
    assign upc_d   = y + AW'(ci & ~irq_take);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            upc_q <= '0;
            r_q   <= '0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= irq_take;
            if (!hold) begin
                upc_q <= upc_d;
                r_q   <= r_d;
            end
        end
    end

    microseq_stack #(
        .AW     (AW),
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clk      (clk),
        .nreset   (nreset),
        .push_i   (st_push),
        .pop_i    (st_pop),
        .clr_i    (st_clr),
        .din_i    (stk_din),
        .tos_o    (tos),
        .full_n_o (full_n),
        .empty_o  (empty),
        .err_o    (stk_err)
    );

endmodule

// File: tb/tb_microseq.sv
// Directed self-checking bench for microseq with hand-computed expected addresses.
module tb_microseq;
    import microseq_pkg::*;

    localparam int unsigned AW     = 12;
    localparam int unsigned SDEPTH = 5;
    localparam int unsigned NCOND  = 32;
    localparam int unsigned CSW    = 5;
`ifdef MICROSEQ_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             nreset;
    logic [3:0]       i;
    logic [AW-1:0]    d;
    logic [NCOND-1:0] cond_vec;
    logic [CSW-1:0]   cond_sel;
    logic             cond_inv, ccen_n, rld_n, ci, hold, irq_req, irq_en;
    logic [AW-1:0]    vec;
    logic [AW-1:0]    y;
    logic             pl_n, map_n, vect_n, full_n, empty, irq_ack, stk_err;

    int n_cmp = 0;
    int n_err = 0;

    microseq #(.AW(AW), .SDEPTH(SDEPTH), .NCOND(NCOND)) dut (
        .clk(clk), .nreset(nreset), .i(i), .d(d), .cond_vec(cond_vec),
        .cond_sel(cond_sel), .cond_inv(cond_inv), .ccen_n(ccen_n), .rld_n(rld_n),
        .ci(ci), .hold(hold), .irq_req(irq_req), .irq_en(irq_en), .vec(vec),
        .y(y), .pl_n(pl_n), .map_n(map_n), .vect_n(vect_n), .full_n(full_n),
        .empty(empty), .irq_ack(irq_ack), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input sqi_e op, input logic [AW-1:0] dv);
        i = op;
        d = dv;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] crtn_exp [5];
        crtn_exp[0] = 12'h07D; crtn_exp[1] = 12'h07B; crtn_exp[2] = 12'h07A;
        crtn_exp[3] = 12'h079; crtn_exp[4] = 12'h078;

        nreset = 1'b0; i = CONT; d = '0; cond_vec = '0; cond_sel = '0; cond_inv = 1'b0;
        ccen_n = 1'b1; rld_n = 1'b1; ci = 1'b1; hold = 1'b0;
        irq_req = 1'b0; irq_en = 1'b0; vec = '0;

        repeat (2) tick();
        check_eq("rst_y", 32'(y), 0);
        check_eq("rst_pl_n", 32'(pl_n), 0);
        check_eq("rst_map_n", 32'(map_n), 1);
        check_eq("rst_vect_n", 32'(vect_n), 1);
        check_eq("rst_empty", 32'(empty), 1);
        check_eq("rst_full_n", 32'(full_n), 1);
        check_eq("rst_irq_ack", 32'(irq_ack), 0);
        check_eq("rst_stk_err", 32'(stk_err), 0);
        nreset = 1'b1;

        // Sequential stepping, then carry held off.
        for (int k = 0; k < 4; k++) begin
            set_op(CONT, '0); check_eq("cont_ci1_y", 32'(y), 32'(k)); tick();
        end
        ci = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_op(CONT, '0); check_eq("cont_ci0_y", 32'(y), 32'h4); tick();
        end
        ci = 1'b1;
        set_op(CONT, '0); check_eq("cont_y4", 32'(y), 32'h4); tick();

        // Subroutine call and return at uPC=5.
        set_op(CJS, 12'h100); check_eq("cjs_y", 32'(y), 32'h100); tick();
        check_eq("cjs_empty", 32'(empty), 0);
        set_op(CRTN, '0); check_eq("crtn_y", 32'(y), 32'h5); tick();
        check_eq("crtn_empty", 32'(empty), 1);

        // Counter load and repeat-on-D.
        set_op(LDCT, 12'd3); check_eq("ldct_y", 32'(y), 32'h6); tick();
        for (int k = 0; k < 3; k++) begin
            set_op(RPCT, 12'h020); check_eq("rpct_d_y", 32'(y), 32'h20); tick();
        end
        set_op(RPCT, 12'h020); check_eq("rpct_end_y", 32'(y), 32'h21); tick();
        set_op(RPCT, 12'h020); check_eq("rpct_r0_y", 32'(y), 32'h22); tick();

        // D-source enables and the condition mux.
        set_op(JMAP, 12'h0AB);
        check_eq("jmap_y", 32'(y), 32'hAB);
        check_eq("jmap_enables", 32'({pl_n, map_n, vect_n}), 32'b101);
        tick();
        ccen_n = 1'b0; cond_sel = 5'd3; cond_vec = '0; cond_inv = 1'b0;
        set_op(CJV, 12'h123);
        check_eq("cjv_fail_y", 32'(y), 32'hAC);
        check_eq("cjv_enables", 32'({pl_n, map_n, vect_n}), 32'b110);
        tick();
        cond_vec = 32'h0000_0008; cond_inv = 1'b1;
        set_op(CJP, 12'h050); check_eq("cjp_inv_fail_y", 32'(y), 32'hAD); tick();
        cond_sel = 5'd31; cond_vec = 32'h8000_0000; cond_inv = 1'b0;
        set_op(CJP, 12'h050); check_eq("cjp_sel31_pass_y", 32'(y), 32'h50); tick();
        ccen_n = 1'b1;
        set_op(LDCT, 12'h077); check_eq("ldct2_y", 32'(y), 32'h51); tick();
        ccen_n = 1'b0; cond_sel = '0; cond_vec = '0;
        set_op(JRP, 12'h300); check_eq("jrp_fail_y", 32'(y), 32'h77); tick();
        ccen_n = 1'b1;

        // Overflow: the sixth push overwrites the top entry.
        for (int k = 0; k < int'(SDEPTH) + 1; k++) begin
            set_op(PUSH, '0); check_eq("push_y", 32'(y), 32'h78 + 32'(k)); tick();
            check_eq("push_full_n", 32'(full_n), (k >= int'(SDEPTH) - 1) ? 0 : 1);
        end
        check_eq("ovf_stk_err", 32'(stk_err), 32'(ERR_EN));
        for (int k = 0; k < int'(SDEPTH); k++) begin
            set_op(CRTN, '0); check_eq("pop_y", 32'(y), 32'(crtn_exp[k])); tick();
            check_eq("pop_empty", 32'(empty), (k == int'(SDEPTH) - 1) ? 1 : 0);
        end
        set_op(CRTN, '0); tick();
        check_eq("udf_empty", 32'(empty), 1);
        check_eq("udf_stk_err", 32'(stk_err), 32'(ERR_EN));
        set_op(JZ, 12'h555); check_eq("jz_y", 32'(y), 0); tick();

        // Interrupt entry during a failing CJP at uPC=7.
        for (int k = 1; k <= 6; k++) begin
            set_op(CONT, '0); check_eq("cont_to7_y", 32'(y), 32'(k)); tick();
        end
        ccen_n = 1'b0; irq_req = 1'b1; irq_en = 1'b1; vec = 12'hFF0;
        set_op(CJP, 12'h444);
        check_eq("irq_y", 32'(y), 32'hFF0);
        check_eq("irq_ack_pre", 32'(irq_ack), 0);
        tick();
        check_eq("irq_ack_pulse", 32'(irq_ack), 1);
        check_eq("irq_empty", 32'(empty), 0);
        ccen_n = 1'b1;
        set_op(CONT, '0); check_eq("irq_ackcyc_y", 32'(y), 32'hFF0); tick();
        check_eq("irq_ack_end", 32'(irq_ack), 0);
        irq_en = 1'b0;
        set_op(CONT, '0); check_eq("irq_dis_y", 32'(y), 32'hFF1); tick();
        check_eq("irq_dis_ack", 32'(irq_ack), 0);
        irq_req = 1'b0;
        set_op(CRTN, '0); check_eq("irq_ret_y", 32'(y), 32'h7); tick();
        check_eq("irq_ret_empty", 32'(empty), 1);

        // Hold in the middle of an RFCT loop; ci=0 exposes any uPC movement.
        set_op(PUSH, 12'd2); check_eq("loop_push_y", 32'(y), 32'h8); tick();
        set_op(RFCT, '0); check_eq("rfct1_y", 32'(y), 32'h8); tick();
        hold = 1'b1; ci = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_op(RFCT, '0);
            check_eq("hold_y", 32'(y), 32'h8);
            check_eq("hold_empty", 32'(empty), 0);
            tick();
            check_eq("hold_ack", 32'(irq_ack), 0);
        end
        hold = 1'b0; ci = 1'b1;
        set_op(RFCT, '0); check_eq("rfct2_y", 32'(y), 32'h8); tick();
        set_op(RFCT, '0); check_eq("rfct_exit_y", 32'(y), 32'h9); tick();
        check_eq("rfct_exit_empty", 32'(empty), 1);

        // Asynchronous reset in the middle of a loop.
        set_op(PUSH, 12'd5); check_eq("loop2_push_y", 32'(y), 32'hA); tick();
        set_op(RFCT, '0); check_eq("loop2_rfct_y", 32'(y), 32'hA);
        #2;
        nreset = 1'b0;
        #1;
        check_eq("arst_y", 32'(y), 0);
        check_eq("arst_empty", 32'(empty), 1);
        check_eq("arst_full_n", 32'(full_n), 1);
        check_eq("arst_enables", 32'({pl_n, map_n, vect_n}), 32'b011);
        tick();
        nreset = 1'b1;
        set_op(RPCT, 12'h033);
        check_eq("post_rst_r0_y", 32'(y), 0);
        check_eq("post_rst_ack", 32'(irq_ack), 0);
        check_eq("post_rst_err", 32'(stk_err), 0);
        tick();
        set_op(CONT, '0); check_eq("post_rst_cont_y", 32'(y), 32'h1); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
